// File: rtl/snake_game_sequencer.sv
// -----------------------------------------------------------------------------
// snake_game_sequencer
//   Paces snake movement and sequences the game state (IDLE/RUN/PAUSE/OVER).
//   A prescaler issues one move_tick per move period. Each tick opens a step
//   with the body-update engine via step_req/step_done. The step result
//   (collision / food_eaten) is sampled only on an accepted step_done.
//
//   Optional feature macro: SEQ_SPEEDUP_EN
//     defined   : each food shortens the move period by TICK_DIV_STEP, down to
//                 a floor of TICK_DIV_MIN.
//     undefined : the move period stays at TICK_DIV_INIT; score still counts.
//
// Ports
//   clk           in   1        system clock
//   rst           in   1        synchronous, active-high reset
//   start_signal  in   1        level; player has pressed a direction
//   pause_btn     in   1        synchronised pause level (edge-detected here)
//   step_done     in   1        pulse: body engine finished the step
//   collision     in   1        step result, qualified by step_done
//   food_eaten    in   1        step result, qualified by step_done
//   move_tick     out  1        pulse at each step start / direction latch
//   step_req      out  1        high from move_tick through step_done
//   state         out  2        00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
//   score         out  SCORE_W  food count, saturating
//   game_over     out  1        high in OVER
// -----------------------------------------------------------------------------
module snake_game_sequencer #(
    parameter int TICK_DIV_INIT = 25_000_000,
    parameter int TICK_DIV_MIN  = 5_000_000,
    parameter int TICK_DIV_STEP = 2_000_000,
    parameter int CNT_W         = 26,
    parameter int SCORE_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_signal,
    input  logic               pause_btn,
    input  logic               step_done,
    input  logic               collision,
    input  logic               food_eaten,
    output logic               move_tick,
    output logic               step_req,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_OVER  = 2'b11;

    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(TICK_DIV_INIT);

    logic [1:0]         state_r;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   div;
    logic [SCORE_W-1:0] score_r;
    logic               step_req_r;
    logic               pause_pend;
    logic               pause_q;

    logic               pause_rise;
    logic               done;
    logic               at_limit;
    logic               tick;
    logic [CNT_W-1:0]   div_dec;
    logic [SCORE_W-1:0] score_inc;

    assign pause_rise = pause_btn & ~pause_q;
    // A step_done with no step outstanding is stray and dropped with its result.
    assign done       = step_done & step_req_r;
    // >= rather than == so a period that shrank below cnt still fires at once.
    assign at_limit   = (cnt >= (div - CNT_W'(1)));
    // A pause edge with no outstanding step wins over a tick due in the same
    // cycle; cnt stays at its limit so the tick fires right after resume.
    assign tick       = !rst && (state_r == S_RUN) && !step_req_r && at_limit && !pause_rise;

`ifdef SEQ_SPEEDUP_EN
    localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(TICK_DIV_MIN);
    localparam logic [CNT_W-1:0] DIV_STEP = CNT_W'(TICK_DIV_STEP);
    localparam logic [CNT_W:0]   DIV_KNEE = {1'b0, DIV_MIN} + {1'b0, DIV_STEP};

    // Subtract only when the result stays at or above the floor, so the
    // decrement can never wrap.
    always_comb begin
        div_dec = DIV_MIN;
        if ({1'b0, div} >= DIV_KNEE)
            div_dec = div - DIV_STEP;
    end
`else
    assign div_dec = div;
`endif

    assign score_inc = (score_r == '1) ? score_r : score_r + SCORE_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            cnt        <= '0;
            div        <= DIV_INIT;
            score_r    <= '0;
            step_req_r <= 1'b0;
            pause_pend <= 1'b0;
            pause_q    <= 1'b0;
        end else begin
            pause_q <= pause_btn;
            case (state_r)
                S_IDLE: begin
                    cnt        <= '0;
                    pause_pend <= 1'b0;
                    if (start_signal)
                        state_r <= S_RUN;
                end
                S_RUN: begin
                    if (tick) begin
                        cnt        <= '0;
                        step_req_r <= 1'b1;
                    end else if (!at_limit) begin
                        cnt <= cnt + CNT_W'(1);
                    end

                    if (done) begin
                        step_req_r <= 1'b0;
                        pause_pend <= 1'b0;
                        if (collision) begin
                            state_r <= S_OVER;
                        end else begin
                            if (food_eaten) begin
                                score_r <= score_inc;
                                div     <= div_dec;
                            end
                            // A pause requested during the step lands now.
                            if (pause_pend || pause_rise)
                                state_r <= S_PAUSE;
                        end
                    end else if (pause_rise) begin
                        if (!step_req_r)
                            state_r <= S_PAUSE;
                        else
                            pause_pend <= 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (pause_rise)
                        state_r <= S_RUN;
                end
                default: ;
            endcase
        end
    end

    assign move_tick = tick;
    assign step_req  = step_req_r | tick;
    assign state     = state_r;
    assign score     = score_r;
    assign game_over = (state_r == S_OVER);

endmodule
